data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Data-memory responder for the MEM stage of the five-stage MIPS pipeline.
- The datapath MEM stage is the initiator: it raises a read or write request, and this block services it after a fixed multi-cycle latency.
- While a request is in flight the block drives a stall to the controller, so the pipeline freezes until the access completes.
- Replaces the ideal single-cycle data memory, so hazard and stall logic can be exercised under realistic memory timing.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two.
- LATENCY, 2: cycles from request acceptance to ready; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  read request from the MEM stage.
- mem_write  input  1  write request from the MEM stage.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data.
- rdata  output  32  load data; valid only while ready=1.
- ready  output  1  one-cycle completion pulse.
- stall  output  1  freeze request to the hazard/control unit.
- err  output  1  one-cycle error pulse, coincident with ready.

Behaviour:
- Reset: one clk with rst=1, synchronous, active-high.
  - State returns to IDLE.
  - rdata=0, ready=0, err=0, stall=0.
  - All memory words are cleared to 0.
  - An access in flight is aborted and its write is never committed.
- States:
  - IDLE: no access in flight.
  - WAIT: access accepted, latency counting down.
  - DONE: completion cycle.
- Acceptance:
  - In IDLE, a request is mem_read|mem_write.
  - On acceptance, latch addr, wdata and the op; load cnt=LATENCY-1.
  - If LATENCY==1, go to DONE; otherwise go to WAIT.
- WAIT: decrement cnt each cycle; when cnt==1, the next state is DONE. Total cycles from acceptance to DONE = LATENCY.
- stall: combinational, (IDLE & request) | WAIT. It is low in DONE, so the pipeline advances at the end of the DONE cycle.
- DONE cycle:
  - ready=1.
  - rdata = mem[index] for a read, 0 for a write.
  - Request inputs are ignored in this cycle, so the still-asserted old request is not re-accepted.
  - Next state is IDLE.
- Writes: committed on the clock edge that enters DONE. A read of the same word in a later access returns the new data.
- Indexing:
  - index = latched addr[log2(DEPTH_WORDS)+1:2].
  - Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
- Error handling:
  - Misaligned address (addr[1:0]!=0): the access still takes LATENCY cycles; in DONE, err=1, rdata=0, and no write occurs.
  - mem_read and mem_write both high: treated as an error with the same handling as a misaligned address.
- Back-to-back: the earliest next acceptance is the cycle after DONE, so issue spacing is LATENCY+1 cycles.
- Inputs changing during WAIT have no effect, because everything is latched at acceptance.
- Outputs ready, err and rdata are registered; stall is the only combinational output.

Decomposition:
- Shared package (mips_pkg):
  - state encoding constants: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - WORD_W=32.
  - the index-width function (clog2).
- Natural sub-module: mem_latency_ctr, the down-counter with load/decrement and a terminal flag. The storage array stays inline.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x10 with L=2.
  - stall=1 for 2 cycles, ready pulses in cycle 3, err=0.
  - A following read of 0x10 returns 0xDEADBEEF with ready.
- Read of a never-written addr 0x40 after reset: rdata=0 with ready.
- Misaligned write to 0x13 with data 0x1234:
  - err=1 and ready=1 in the same cycle.
  - A subsequent aligned read of 0x10 is unchanged (0xDEADBEEF).
- mem_read held high through the DONE cycle: no second acceptance, stall=0 in DONE. A request held into the next cycle is accepted as a new access.
- Aliasing with DEPTH=256: write 0xA5A5A5A5 to 0x400, read 0x000 → 0xA5A5A5A5.
- Mid-write reset and edge cases:
  - Assert rst during WAIT of a write to 0x20: all outputs 0, and a subsequent read of 0x20 returns 0.
  - Repeat the directed reads and writes with LATENCY=1 and LATENCY=15 to confirm stall length equals LATENCY.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS data-memory responder: word width,
// responder state encoding and the address-index width helper.
package mips_pkg;

    localparam int WORD_W = 32;

    // Width of the latency down-counter; covers LATENCY up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of index bits needed to address `depth` words (ceil(log2)).
    function automatic int idx_width(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_latency_ctr.sv
// Loadable down-counter that times the access latency. The terminal flag
// is raised while the count sits at 1, i.e. one cycle before completion.
module mem_latency_ctr
    import mips_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load has priority, decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage. A read or write is accepted
// in IDLE, held for LATENCY cycles while the pipeline is stalled, and
// completed with a one-cycle ready (and err for bad requests) pulse.
module data_mem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              stall,
    output logic              err
);

    localparam int IDX_W = idx_width(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    state_e            state_q;
    logic              op_rd_q;
    logic              op_wr_q;
    logic              bad_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rdata_q;
    logic              ready_q;
    logic              err_q;
    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    logic              request;
    logic              accept;
    logic              cnt_last;
    logic              enter_done;
    logic              live_bad;
    logic              cur_rd;
    logic              cur_wr;
    logic              cur_bad;
    logic [IDX_W-1:0]  cur_idx;
    logic [WORD_W-1:0] cur_wdata;
    logic [WORD_W-1:0] rd_word;

    // Address bits above the index only alias; byte-offset bits feed the
    // misalignment check.
    logic addr_hi_unused;
    assign addr_hi_unused = ^addr[WORD_W-1:IDX_W+2];

    assign request  = mem_read | mem_write;
    assign accept   = (state_q == IDLE) && request;
    assign live_bad = (addr[1:0] != 2'b00) || (mem_read && mem_write);

    // With LATENCY==1 the completion edge is the acceptance edge, so the
    // access parameters must come straight from the inputs there.
    always_comb begin
        cur_rd    = op_rd_q;
        cur_wr    = op_wr_q;
        cur_bad   = bad_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        if (state_q == IDLE) begin
            cur_rd    = mem_read;
            cur_wr    = mem_write;
            cur_bad   = live_bad;
            cur_idx   = addr[IDX_W+1:2];
            cur_wdata = wdata;
        end
    end

    // Edge that moves the FSM into DONE: completion registers load here
    // and the write (if any) commits here.
    always_comb begin
        enter_done = 1'b0;
        if ((LATENCY == 1) && accept) begin
            enter_done = 1'b1;
        end else if ((state_q == WAIT) && cnt_last) begin
            enter_done = 1'b1;
        end
    end

    assign rd_word = mem_q[cur_idx];

    mem_latency_ctr u_ctr (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (accept),
        .dec_i      (state_q == WAIT),
        .load_val_i (LOAD_VAL),
        .last_o     (cnt_last)
    );

    // Responder FSM: latches the request on acceptance and produces the
    // registered completion outputs for the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_rd_q <= 1'b0;
            op_wr_q <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= enter_done;
            err_q   <= enter_done && cur_bad;
            rdata_q <= (enter_done && cur_rd && !cur_bad) ? rd_word : '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_rd_q <= mem_read;
                        op_wr_q <= mem_write;
                        bad_q   <= live_bad;
                        idx_q   <= addr[IDX_W+1:2];
                        wdata_q <= wdata;
                        state_q <= (LATENCY == 1) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_last) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Storage array: cleared on reset, written on the completion edge of
    // a well-formed write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (enter_done && cur_wr && !cur_bad) begin
            mem_q[cur_idx] <= cur_wdata;
        end
    end

    assign stall = accept || (state_q == WAIT);
    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule
